// File: rtl/hacd_pkg.sv
// Shared types for the Hawk memory-controller AXI arbiter.
package hacd_pkg;

    localparam int unsigned HAWK_ARB_NUM_MST = 2;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA
    } wr_arb_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_ADDR
    } rd_arb_state_t;

endpackage

// File: rtl/hacd_mc_axi_rd_bus.sv
// AXI4 read channels (AR, R) of the memory-controller port.
interface HACD_MC_AXI_RD_BUS #(
    parameter int unsigned ID_W   = 6,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 256
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport mstr (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slv (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/hacd_mc_axi_wr_bus.sv
// AXI4 write channels (AW, W, B) of the memory-controller port.
interface HACD_MC_AXI_WR_BUS #(
    parameter int unsigned ID_W   = 6,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 256
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport mstr (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slv (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/hawk_rr_arb2.sv
// Two-way round-robin picker; pointer names the master preferred on a tie.
module hawk_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       gnt_idx_o,
    output logic       gnt_vld_o
);

    logic ptr_q;

    // A lone requester wins outright; a tie goes to the pointer.
    always_comb begin
        gnt_vld_o = |req_i;
        gnt_idx_o = (req_i == 2'b11) ? ptr_q : req_i[1];
    end

    // After a grant the loser becomes the preferred master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (advance_i && gnt_vld_o) begin
            ptr_q <= ~gnt_idx_o;
        end
    end

endmodule

// File: rtl/hawk_axi_mc_arb.sv
// Two-master to one-slave AXI4 arbiter in front of the memory-controller port.
// Slave-side IDs carry the master index in the MSB so responses route back.
module hawk_axi_mc_arb
    import hacd_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned ID_W      = 6
) (
    input logic            clk,
    input logic            rst_n,
    HACD_MC_AXI_WR_BUS.slv  m0_wr_bus,
    HACD_MC_AXI_RD_BUS.slv  m0_rd_bus,
    HACD_MC_AXI_WR_BUS.slv  m1_wr_bus,
    HACD_MC_AXI_RD_BUS.slv  m1_rd_bus,
    HACD_MC_AXI_WR_BUS.mstr s_wr_bus,
    HACD_MC_AXI_RD_BUS.mstr s_rd_bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    wr_arb_state_t wr_state_q;
    rd_arb_state_t rd_state_q;
    logic          wr_gnt_q, rd_gnt_q;
    cnt_t          wr_cnt_q [HAWK_ARB_NUM_MST];
    cnt_t          wr_cnt_d [HAWK_ARB_NUM_MST];
    cnt_t          rd_cnt_q [HAWK_ARB_NUM_MST];
    cnt_t          rd_cnt_d [HAWK_ARB_NUM_MST];

    logic [1:0] aw_req, ar_req;
    logic       aw_adv, ar_adv, aw_gnt_idx, ar_gnt_idx, aw_gnt_vld, ar_gnt_vld;
    logic       aw_hs, w_hs, b_hs, ar_hs, r_last_hs, b_sel, r_sel;
    logic       unused_id_msb;

    function automatic cnt_t cnt_upd(cnt_t q, logic inc, logic dec);
        cnt_t r;
        r = q;
        if (inc && !dec) begin
            r = q + 1'b1;
        end else if (dec && !inc && (q != '0)) begin
            r = q - 1'b1;
        end
        return r;
    endfunction

    // Eligibility only matters in idle; a capped master cannot request.
    always_comb begin
        aw_req[0] = (wr_state_q == WR_IDLE) && m0_wr_bus.awvalid && (wr_cnt_q[0] < cnt_t'(MAX_OUTST));
        aw_req[1] = (wr_state_q == WR_IDLE) && m1_wr_bus.awvalid && (wr_cnt_q[1] < cnt_t'(MAX_OUTST));
        ar_req[0] = (rd_state_q == RD_IDLE) && m0_rd_bus.arvalid && (rd_cnt_q[0] < cnt_t'(MAX_OUTST));
        ar_req[1] = (rd_state_q == RD_IDLE) && m1_rd_bus.arvalid && (rd_cnt_q[1] < cnt_t'(MAX_OUTST));
        aw_adv    = (wr_state_q == WR_IDLE) && aw_gnt_vld;
        ar_adv    = (rd_state_q == RD_IDLE) && ar_gnt_vld;
    end

    hawk_rr_arb2 u_aw_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (aw_req),
        .advance_i (aw_adv),
        .gnt_idx_o (aw_gnt_idx),
        .gnt_vld_o (aw_gnt_vld)
    );

    hawk_rr_arb2 u_ar_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (ar_req),
        .advance_i (ar_adv),
        .gnt_idx_o (ar_gnt_idx),
        .gnt_vld_o (ar_gnt_vld)
    );

    // Write FSM: grant, address handshake, then W locked to the grantee until wlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            wr_gnt_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE: if (aw_gnt_vld) begin
                    wr_gnt_q   <= aw_gnt_idx;
                    wr_state_q <= WR_ADDR;
                end
                WR_ADDR: if (aw_hs) wr_state_q <= WR_DATA;
                WR_DATA: if (w_hs && s_wr_bus.wlast) wr_state_q <= WR_IDLE;
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Read FSM: grant then address handshake; no data lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_gnt_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                RD_IDLE: if (ar_gnt_vld) begin
                    rd_gnt_q   <= ar_gnt_idx;
                    rd_state_q <= RD_ADDR;
                end
                RD_ADDR: if (ar_hs) rd_state_q <= RD_IDLE;
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // AW and W muxing from the write grantee; the other master sees no ready.
    always_comb begin
        s_wr_bus.awvalid = (wr_state_q == WR_ADDR);
        if (wr_gnt_q) begin
            s_wr_bus.awid    = {1'b1, m1_wr_bus.awid[ID_W-2:0]};
            s_wr_bus.awaddr  = m1_wr_bus.awaddr;
            s_wr_bus.awlen   = m1_wr_bus.awlen;
            s_wr_bus.awsize  = m1_wr_bus.awsize;
            s_wr_bus.awburst = m1_wr_bus.awburst;
            s_wr_bus.wdata   = m1_wr_bus.wdata;
            s_wr_bus.wstrb   = m1_wr_bus.wstrb;
            s_wr_bus.wlast   = m1_wr_bus.wlast;
            s_wr_bus.wvalid  = (wr_state_q == WR_DATA) && m1_wr_bus.wvalid;
        end else begin
            s_wr_bus.awid    = {1'b0, m0_wr_bus.awid[ID_W-2:0]};
            s_wr_bus.awaddr  = m0_wr_bus.awaddr;
            s_wr_bus.awlen   = m0_wr_bus.awlen;
            s_wr_bus.awsize  = m0_wr_bus.awsize;
            s_wr_bus.awburst = m0_wr_bus.awburst;
            s_wr_bus.wdata   = m0_wr_bus.wdata;
            s_wr_bus.wstrb   = m0_wr_bus.wstrb;
            s_wr_bus.wlast   = m0_wr_bus.wlast;
            s_wr_bus.wvalid  = (wr_state_q == WR_DATA) && m0_wr_bus.wvalid;
        end
        m0_wr_bus.awready = (wr_state_q == WR_ADDR) && !wr_gnt_q && s_wr_bus.awready;
        m1_wr_bus.awready = (wr_state_q == WR_ADDR) &&  wr_gnt_q && s_wr_bus.awready;
        m0_wr_bus.wready  = (wr_state_q == WR_DATA) && !wr_gnt_q && s_wr_bus.wready;
        m1_wr_bus.wready  = (wr_state_q == WR_DATA) &&  wr_gnt_q && s_wr_bus.wready;
    end

    // AR muxing from the read grantee.
    always_comb begin
        s_rd_bus.arvalid = (rd_state_q == RD_ADDR);
        if (rd_gnt_q) begin
            s_rd_bus.arid    = {1'b1, m1_rd_bus.arid[ID_W-2:0]};
            s_rd_bus.araddr  = m1_rd_bus.araddr;
            s_rd_bus.arlen   = m1_rd_bus.arlen;
            s_rd_bus.arsize  = m1_rd_bus.arsize;
            s_rd_bus.arburst = m1_rd_bus.arburst;
        end else begin
            s_rd_bus.arid    = {1'b0, m0_rd_bus.arid[ID_W-2:0]};
            s_rd_bus.araddr  = m0_rd_bus.araddr;
            s_rd_bus.arlen   = m0_rd_bus.arlen;
            s_rd_bus.arsize  = m0_rd_bus.arsize;
            s_rd_bus.arburst = m0_rd_bus.arburst;
        end
        m0_rd_bus.arready = (rd_state_q == RD_ADDR) && !rd_gnt_q && s_rd_bus.arready;
        m1_rd_bus.arready = (rd_state_q == RD_ADDR) &&  rd_gnt_q && s_rd_bus.arready;
    end

    // B and R route back by the ID MSB; the MSB is cleared toward the master.
    always_comb begin
        b_sel             = s_wr_bus.bid[ID_W-1];
        r_sel             = s_rd_bus.rid[ID_W-1];
        m0_wr_bus.bid     = {1'b0, s_wr_bus.bid[ID_W-2:0]};
        m1_wr_bus.bid     = {1'b0, s_wr_bus.bid[ID_W-2:0]};
        m0_wr_bus.bresp   = s_wr_bus.bresp;
        m1_wr_bus.bresp   = s_wr_bus.bresp;
        m0_wr_bus.bvalid  = s_wr_bus.bvalid && !b_sel;
        m1_wr_bus.bvalid  = s_wr_bus.bvalid &&  b_sel;
        s_wr_bus.bready   = b_sel ? m1_wr_bus.bready : m0_wr_bus.bready;
        m0_rd_bus.rid     = {1'b0, s_rd_bus.rid[ID_W-2:0]};
        m1_rd_bus.rid     = {1'b0, s_rd_bus.rid[ID_W-2:0]};
        m0_rd_bus.rdata   = s_rd_bus.rdata;
        m1_rd_bus.rdata   = s_rd_bus.rdata;
        m0_rd_bus.rresp   = s_rd_bus.rresp;
        m1_rd_bus.rresp   = s_rd_bus.rresp;
        m0_rd_bus.rlast   = s_rd_bus.rlast;
        m1_rd_bus.rlast   = s_rd_bus.rlast;
        m0_rd_bus.rvalid  = s_rd_bus.rvalid && !r_sel;
        m1_rd_bus.rvalid  = s_rd_bus.rvalid &&  r_sel;
        s_rd_bus.rready   = r_sel ? m1_rd_bus.rready : m0_rd_bus.rready;
        aw_hs             = s_wr_bus.awvalid && s_wr_bus.awready;
        w_hs              = s_wr_bus.wvalid && s_wr_bus.wready;
        b_hs              = s_wr_bus.bvalid && s_wr_bus.bready;
        ar_hs             = s_rd_bus.arvalid && s_rd_bus.arready;
        r_last_hs         = s_rd_bus.rvalid && s_rd_bus.rready && s_rd_bus.rlast;
        unused_id_msb     = ^{m0_wr_bus.awid[ID_W-1], m1_wr_bus.awid[ID_W-1],
                              m0_rd_bus.arid[ID_W-1], m1_rd_bus.arid[ID_W-1]};
    end

    // Outstanding counters: request handshake increments, final response decrements.
    always_comb begin
        for (int unsigned m = 0; m < HAWK_ARB_NUM_MST; m++) begin
            wr_cnt_d[m] = cnt_upd(wr_cnt_q[m], aw_hs && (wr_gnt_q == 1'(m)),
                                  b_hs && (b_sel == 1'(m)));
            rd_cnt_d[m] = cnt_upd(rd_cnt_q[m], ar_hs && (rd_gnt_q == 1'(m)),
                                  r_last_hs && (r_sel == 1'(m)));
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '{default: '0};
            rd_cnt_q <= '{default: '0};
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // A response with nothing outstanding for its master is a slave protocol error.
    a_b_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        b_hs |-> (wr_cnt_q[b_sel] != '0));
    a_r_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        r_last_hs |-> (rd_cnt_q[r_sel] != '0));

endmodule

// File: tb/tb_hawk_axi_mc_arb.sv
// Directed bench for the two-master AXI arbiter; bench acts as both masters and the slave.
module tb_hawk_axi_mc_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    HACD_MC_AXI_WR_BUS #(.ID_W(6)) m0_wr ();
    HACD_MC_AXI_RD_BUS #(.ID_W(6)) m0_rd ();
    HACD_MC_AXI_WR_BUS #(.ID_W(6)) m1_wr ();
    HACD_MC_AXI_RD_BUS #(.ID_W(6)) m1_rd ();
    HACD_MC_AXI_WR_BUS #(.ID_W(6)) s_wr ();
    HACD_MC_AXI_RD_BUS #(.ID_W(6)) s_rd ();

    hawk_axi_mc_arb #(.MAX_OUTST(4), .ID_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_wr_bus (m0_wr),
        .m0_rd_bus (m0_rd),
        .m1_wr_bus (m1_wr),
        .m1_rd_bus (m1_rd),
        .s_wr_bus  (s_wr),
        .s_rd_bus  (s_rd)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_wr.awvalid = 0; m0_wr.awid = 0; m0_wr.awaddr = 0; m0_wr.awlen = 0;
        m0_wr.awsize = 3'd5; m0_wr.awburst = 2'd1;
        m0_wr.wvalid = 0; m0_wr.wdata = 0; m0_wr.wstrb = 0; m0_wr.wlast = 0; m0_wr.bready = 1;
        m1_wr.awvalid = 0; m1_wr.awid = 0; m1_wr.awaddr = 0; m1_wr.awlen = 0;
        m1_wr.awsize = 3'd5; m1_wr.awburst = 2'd1;
        m1_wr.wvalid = 0; m1_wr.wdata = 0; m1_wr.wstrb = 0; m1_wr.wlast = 0; m1_wr.bready = 1;
        m0_rd.arvalid = 0; m0_rd.arid = 0; m0_rd.araddr = 0; m0_rd.arlen = 0;
        m0_rd.arsize = 3'd5; m0_rd.arburst = 2'd1; m0_rd.rready = 1;
        m1_rd.arvalid = 0; m1_rd.arid = 0; m1_rd.araddr = 0; m1_rd.arlen = 0;
        m1_rd.arsize = 3'd5; m1_rd.arburst = 2'd1; m1_rd.rready = 1;
        s_wr.awready = 1; s_wr.wready = 1; s_wr.bvalid = 0; s_wr.bid = 0; s_wr.bresp = 0;
        s_rd.arready = 1; s_rd.rvalid = 0; s_rd.rid = 0; s_rd.rdata = 0; s_rd.rresp = 0;
        s_rd.rlast = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drive_aw(input int m, input logic v, input logic [5:0] id,
                            input logic [63:0] addr, input logic [7:0] len);
        if (m == 0) begin
            m0_wr.awvalid = v; m0_wr.awid = id; m0_wr.awaddr = addr; m0_wr.awlen = len;
        end else begin
            m1_wr.awvalid = v; m1_wr.awid = id; m1_wr.awaddr = addr; m1_wr.awlen = len;
        end
    endtask

    task automatic drive_w(input int m, input logic v, input logic [255:0] d, input logic last);
        if (m == 0) begin
            m0_wr.wvalid = v; m0_wr.wdata = d; m0_wr.wstrb = '1; m0_wr.wlast = last;
        end else begin
            m1_wr.wvalid = v; m1_wr.wdata = d; m1_wr.wstrb = '1; m1_wr.wlast = last;
        end
    endtask

    task automatic drive_ar(input int m, input logic v, input logic [5:0] id);
        if (m == 0) begin
            m0_rd.arvalid = v; m0_rd.arid = id;
        end else begin
            m1_rd.arvalid = v; m1_rd.arid = id;
        end
    endtask

    // Waits (bounded) until s_awvalid is up; returns at the sample point of that cycle.
    task automatic aw_wait(input string tag);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            if (s_wr.awvalid) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    task automatic ar_wait(input string tag);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            if (s_rd.arvalid) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    // Sends a burst from master m while in WR_DATA; checks passthrough and the lock.
    task automatic w_send(input int m, input int beats, input logic [255:0] base);
        logic [255:0] d;
        for (int b = 0; b < beats; b++) begin
            d = base + 256'(b);
            drive_w(m, 1'b1, d, (b == beats - 1));
            #1;
            check("w_valid", s_wr.wvalid, 1);
            check("w_data", s_wr.wdata, d);
            check("w_strb", s_wr.wstrb, 32'hFFFF_FFFF);
            check("w_last", s_wr.wlast, (b == beats - 1));
            check("w_rdy_own", (m == 0) ? m0_wr.wready : m1_wr.wready, 1);
            check("w_rdy_other", (m == 0) ? m1_wr.wready : m0_wr.wready, 0);
            tick();
        end
        drive_w(m, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        // Reset state, with requests pending on the masters.
        rst_n = 1'b0;
        idle_inputs();
        drive_aw(0, 1, 6'h03, 64'h1000, 8'd1);
        drive_ar(1, 1, 6'h07);
        #1;
        check("rst_s_awvalid", s_wr.awvalid, 0);
        check("rst_s_wvalid", s_wr.wvalid, 0);
        check("rst_s_arvalid", s_rd.arvalid, 0);
        check("rst_m0_awready", m0_wr.awready, 0);
        check("rst_m1_arready", m1_rd.arready, 0);
        check("rst_m0_wready", m0_wr.wready, 0);
        repeat (2) @(posedge clk);
        #2;
        drive_ar(1, 0, 6'h00);
        rst_n = 1'b1;

        // Single write from m0: id 3, 2 beats.
        #1;
        check("aw_lat0", s_wr.awvalid, 0);
        aw_wait("w1_aw_seen");
        check("w1_awid", s_wr.awid, 6'h03);
        check("w1_awaddr", s_wr.awaddr, 64'h1000);
        check("w1_awlen", s_wr.awlen, 8'd1);
        check("w1_m0_awready", m0_wr.awready, 1);
        check("w1_m1_awready", m1_wr.awready, 0);
        tick();
        drive_aw(0, 0, 6'h03, 64'h1000, 8'd1);
        w_send(0, 2, 256'hA000);
        #1;
        check("w1_s_wvalid_done", s_wr.wvalid, 0);
        check("w1_cnt_after_aw", dut.wr_cnt_q[0], 1);
        s_wr.bvalid = 1; s_wr.bid = 6'h03;
        #1;
        check("w1_m0_bvalid", m0_wr.bvalid, 1);
        check("w1_m1_bvalid", m1_wr.bvalid, 0);
        check("w1_m0_bid", m0_wr.bid, 6'h03);
        check("w1_s_bready", s_wr.bready, 1);
        tick();
        s_wr.bvalid = 0;
        #1;
        check("w1_cnt_after_b", dut.wr_cnt_q[0], 0);

        // Simultaneous AW after reset; m1 drives W early and must be held off.
        do_reset();
        drive_aw(0, 1, 6'h01, 64'h2000, 8'd0);
        drive_aw(1, 1, 6'h02, 64'h3000, 8'd0);
        aw_wait("rr1_aw_a");
        check("rr1_first_id", s_wr.awid, 6'h01);
        tick();
        drive_aw(0, 0, 6'h01, 64'h2000, 8'd0);
        drive_w(1, 1'b1, 256'hBAD0, 1'b1);
        w_send(0, 1, 256'hB000);
        #1;
        check("lock_m1_wready_idle", m1_wr.wready, 0);
        aw_wait("rr1_aw_b");
        check("rr1_second_id", s_wr.awid, 6'h22);
        check("lock_m1_wready_addr", m1_wr.wready, 0);
        check("lock_s_wvalid_addr", s_wr.wvalid, 0);
        tick();
        drive_aw(1, 0, 6'h02, 64'h3000, 8'd0);
        w_send(1, 1, 256'hC000);

        // m0 alone moves the pointer to m1; next tie then goes to m1.
        drive_aw(0, 1, 6'h04, 64'h4000, 8'd0);
        aw_wait("rr2_aw_solo");
        check("rr2_solo_id", s_wr.awid, 6'h04);
        tick();
        drive_aw(0, 0, 6'h04, 64'h4000, 8'd0);
        w_send(0, 1, 256'hD000);
        drive_aw(0, 1, 6'h25, 64'h5000, 8'd0);
        drive_aw(1, 1, 6'h06, 64'h6000, 8'd0);
        aw_wait("rr2_aw_a");
        check("rr2_first_id", s_wr.awid, 6'h26);
        tick();
        drive_aw(1, 0, 6'h06, 64'h6000, 8'd0);
        w_send(1, 1, 256'hE000);
        aw_wait("rr2_aw_b");
        check("rr2_second_id_msb_ignored", s_wr.awid, 6'h05);
        tick();
        drive_aw(0, 0, 6'h25, 64'h5000, 8'd0);
        w_send(0, 1, 256'hF000);
        #1;
        check("rr2_wr_cnt0", dut.wr_cnt_q[0], 3);
        check("rr2_wr_cnt1", dut.wr_cnt_q[1], 2);

        // Read cap: m1 holds arvalid; only 4 reach the slave.
        do_reset();
        begin
            int n_ar = 0;
            drive_ar(1, 1, 6'h07);
            for (int i = 0; i < 24; i++) begin
                #1;
                if (s_rd.arvalid) n_ar++;
                tick();
            end
            check("cap_ar_count", n_ar, 4);
        end
        #1;
        check("cap_rd_cnt1", dut.rd_cnt_q[1], 4);
        check("cap_s_arvalid", s_rd.arvalid, 0);
        check("cap_m1_arready", m1_rd.arready, 0);
        drive_ar(0, 1, 6'h05);
        ar_wait("cap_m0_ar_seen");
        check("cap_m0_arid", s_rd.arid, 6'h05);
        tick();
        drive_ar(0, 0, 6'h05);
        #1;
        check("cap_rd_cnt0", dut.rd_cnt_q[0], 1);

        // m0 AR handshake coincides with m0 rlast handshake: count unchanged.
        drive_ar(0, 1, 6'h05);
        ar_wait("incdec_ar_seen");
        s_rd.rvalid = 1; s_rd.rid = 6'h05; s_rd.rlast = 1; s_rd.rdata = 256'h1111;
        #1;
        check("incdec_m0_rvalid", m0_rd.rvalid, 1);
        tick();
        drive_ar(0, 0, 6'h05);
        s_rd.rvalid = 0;
        #1;
        check("incdec_rd_cnt0", dut.rd_cnt_q[0], 1);

        // One m1 rlast frees a slot; 5th AR issues within 2 cycles.
        s_rd.rvalid = 1; s_rd.rid = 6'h27; s_rd.rlast = 1; s_rd.rdata = 256'h2222;
        #1;
        check("r_m1_rvalid", m1_rd.rvalid, 1);
        check("r_m0_rvalid", m0_rd.rvalid, 0);
        check("r_m1_rid", m1_rd.rid, 6'h07);
        check("r_m1_rdata", m1_rd.rdata, 256'h2222);
        tick();
        s_rd.rvalid = 0;
        begin
            bit ok = 0;
            for (int k = 0; k < 2; k++) begin
                tick();
                #1;
                if (s_rd.arvalid) begin
                    ok = 1;
                    break;
                end
            end
            check("cap_5th_ar_2cyc", ok, 1);
        end
        check("cap_5th_arid", s_rd.arid, 6'h27);
        tick();
        drive_ar(1, 0, 6'h07);

        // Interleaved responses: rid 0x25 (2 beats) to m1, then 0x05 to m0 with backpressure.
        s_rd.rvalid = 1; s_rd.rid = 6'h25; s_rd.rlast = 0; s_rd.rdata = 256'h3333;
        #1;
        check("il_m1_rvalid", m1_rd.rvalid, 1);
        check("il_m1_rid", m1_rd.rid, 6'h05);
        check("il_m0_rvalid", m0_rd.rvalid, 0);
        tick();
        #1;
        check("il_cnt1_not_last", dut.rd_cnt_q[1], 4);
        s_rd.rlast = 1; s_rd.rdata = 256'h3334;
        tick();
        #1;
        check("il_cnt1_last", dut.rd_cnt_q[1], 3);
        s_rd.rid = 6'h05; s_rd.rdata = 256'h4444; m0_rd.rready = 0;
        #1;
        check("il_bp_s_rready", s_rd.rready, 0);
        check("il_m0_rvalid2", m0_rd.rvalid, 1);
        check("il_m0_rid", m0_rd.rid, 6'h05);
        tick();
        #1;
        check("il_bp_cnt0", dut.rd_cnt_q[0], 1);
        m0_rd.rready = 1;
        #1;
        check("il_s_rready", s_rd.rready, 1);
        tick();
        s_rd.rvalid = 0;
        #1;
        check("il_cnt0_done", dut.rd_cnt_q[0], 0);

        // Reset during beat 1 of 2, then a fresh write.
        do_reset();
        drive_aw(0, 1, 6'h03, 64'h7000, 8'd1);
        aw_wait("mr_aw_seen");
        tick();
        drive_aw(0, 0, 6'h03, 64'h7000, 8'd1);
        drive_w(0, 1'b1, 256'h5555, 1'b0);
        #1;
        check("mr_wvalid_pre", s_wr.wvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mr_s_wvalid", s_wr.wvalid, 0);
        check("mr_m0_wready", m0_wr.wready, 0);
        check("mr_s_awvalid", s_wr.awvalid, 0);
        check("mr_wr_cnt0", dut.wr_cnt_q[0], 0);
        do_reset();
        drive_aw(0, 1, 6'h03, 64'h8000, 8'd1);
        aw_wait("mr2_aw_seen");
        check("mr2_awid", s_wr.awid, 6'h03);
        tick();
        drive_aw(0, 0, 6'h03, 64'h8000, 8'd1);
        w_send(0, 2, 256'h6000);
        s_wr.bvalid = 1; s_wr.bid = 6'h03;
        #1;
        check("mr2_m0_bvalid", m0_wr.bvalid, 1);
        tick();
        s_wr.bvalid = 0;
        #1;
        check("mr2_wr_cnt0", dut.wr_cnt_q[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
